// File: rtl/motor_cmd_pkg.sv
// Shared types and register-layout constants for the motor command reader.
// Command words are polled from the SPI register file written by the Pi.
package motor_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdCa,
    StRdMot,
    StRdCb,
    StApply
  } cmd_state_t;

  localparam int unsigned MOT_OFS  = 0;
  localparam int unsigned CTRL_OFS = 1;
  localparam int unsigned SEQ_LSB  = 8;
  localparam int unsigned SEQ_W    = 8;
  localparam int unsigned EN_BIT   = 0;
  localparam int unsigned DUTY_W   = 16;

  // One extra bit so that the most negative duty keeps its full magnitude.
  function automatic logic [DUTY_W:0] duty_abs(input logic [DUTY_W-1:0] duty);
    logic [DUTY_W:0] ext;
    ext = {duty[DUTY_W-1], duty};
    if (duty[DUTY_W-1]) begin
      return ~ext + (DUTY_W + 1)'(1);
    end
    return ext;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Single-channel PWM: free-running period counter, shadow magnitude/direction
// loaded only on the wrap cycle, and a counter-below-magnitude compare.
module pwm_gen #(
  parameter int unsigned Period = 2500,
  parameter int unsigned MagW   = $clog2(Period + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [MagW-1:0] pend_mag,
  input  logic            pend_dir,
  output logic            pwm,
  output logic            dir
);

  localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [MagW-1:0] act_mag_q;
  logic            dir_q;
  logic            wrap;

  assign wrap = (cnt_q == CntW'(Period - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      act_mag_q <= '0;
      dir_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      // Duty changes only at the period boundary, so no runt pulses.
      if (wrap) begin
        act_mag_q <= pend_mag;
        dir_q     <= pend_dir;
      end
    end
  end

  assign pwm = (MagW'(cnt_q) < act_mag_q);
  assign dir = dir_q;

endmodule

// File: rtl/motor_cmd_reader.sv
// Polls Pi-written motor commands (CTRL, MOT, CTRL), rejects torn reads and
// drives two signed PWM motors. Optional watchdog: define MOTOR_CMD_WDOG_EN.
module motor_cmd_reader
  import motor_cmd_pkg::*;
#(
  parameter int unsigned CMD_BASE    = 3,
  parameter int unsigned PWM_PERIOD  = 2500,
  parameter int unsigned POLL_DIV    = 500,
  parameter int unsigned WDOG_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic        pwm_l,
  output logic        pwm_r,
  output logic        dir_l,
  output logic        dir_r,
  output logic        enabled,
  output logic [7:0]  cmd_seq,
  output logic        timeout
);

  localparam int unsigned MagW  = $clog2(PWM_PERIOD + 1);
  localparam int unsigned PollW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned CtrlW = SEQ_W + 1;

  // Only seq and enable take part in the torn-read comparison.
  function automatic logic [CtrlW-1:0] ctrl_fields(input logic [31:0] w);
    return {w[SEQ_LSB +: SEQ_W], w[EN_BIT]};
  endfunction

  function automatic logic [MagW-1:0] sat_mag(input logic [DUTY_W:0] mag);
    if (32'(mag) >= PWM_PERIOD) begin
      return MagW'(PWM_PERIOD);
    end
    return MagW'(mag);
  endfunction

  cmd_state_t       state_q, state_d;
  logic [PollW-1:0] poll_q, poll_d;
  logic             gap_q;
  logic             take, commit, trip;
  logic [CtrlW-1:0] ctrl_a_q, ctrl_b;
  logic [31:0]      mot_q;
  logic [SEQ_W-1:0] seq_q;
  logic             en_q;
  logic [MagW-1:0]  pend_mag_l_q, pend_mag_r_q, mag_l, mag_r;
  logic             pend_dir_l_q, pend_dir_r_q;

  // gap_q keeps rd_en low for one cycle after every grant.
  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      StIdle: begin
        if (poll_q == PollW'(POLL_DIV - 1)) begin
          poll_d  = '0;
          state_d = StRdCa;
        end else begin
          poll_d = poll_q + PollW'(1);
        end
      end
      StRdCa: begin
        rd_en   = !gap_q;
        rd_addr = 32'(CMD_BASE + CTRL_OFS);
        if (!gap_q && rd_ack) state_d = StRdMot;
      end
      StRdMot: begin
        rd_en   = !gap_q;
        rd_addr = 32'(CMD_BASE + MOT_OFS);
        if (!gap_q && rd_ack) state_d = StRdCb;
      end
      StRdCb: begin
        rd_en   = !gap_q;
        rd_addr = 32'(CMD_BASE + CTRL_OFS);
        if (!gap_q && rd_ack) state_d = StApply;
      end
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
    end
  end

  assign take   = rd_en && rd_ack;
  assign ctrl_b = ctrl_fields(rd_data);
  assign commit = (state_q == StRdCb) && take && (ctrl_b == ctrl_a_q) &&
                  (ctrl_b[CtrlW-1:1] != seq_q);
  assign mag_l  = sat_mag(duty_abs(mot_q[2*DUTY_W-1 -: DUTY_W]));
  assign mag_r  = sat_mag(duty_abs(mot_q[DUTY_W-1:0]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q        <= 1'b0;
      ctrl_a_q     <= '0;
      mot_q        <= '0;
      seq_q        <= '0;
      en_q         <= 1'b0;
      pend_mag_l_q <= '0;
      pend_mag_r_q <= '0;
      pend_dir_l_q <= 1'b0;
      pend_dir_r_q <= 1'b0;
    end else begin
      gap_q <= take;
      if (state_q == StRdCa && take) ctrl_a_q <= ctrl_b;
      if (state_q == StRdMot && take) mot_q <= rd_data;
      if (commit) begin
        seq_q        <= ctrl_b[CtrlW-1:1];
        en_q         <= ctrl_b[0];
        pend_mag_l_q <= ctrl_b[0] ? mag_l : '0;
        pend_mag_r_q <= ctrl_b[0] ? mag_r : '0;
        pend_dir_l_q <= mot_q[2*DUTY_W-1];
        pend_dir_r_q <= mot_q[DUTY_W-1];
      end else if (trip) begin
        pend_mag_l_q <= '0;
        pend_mag_r_q <= '0;
      end
    end
  end

`ifdef MOTOR_CMD_WDOG_EN
  localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);

  logic [WdW-1:0] wdog_q;
  logic           timeout_q;

  // A commit in the expiry cycle wins, so trip is masked by commit.
  assign trip = !commit && !timeout_q && (wdog_q == WdW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else if (commit) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else if (!timeout_q) begin
      wdog_q <= wdog_q + WdW'(1);
      if (trip) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^32'(WDOG_CYCLES);
  assign trip            = 1'b0;
  assign timeout         = 1'b0;
`endif

  pwm_gen #(
    .Period (PWM_PERIOD),
    .MagW   (MagW)
  ) u_pwm_l (
    .clk      (clk),
    .reset    (reset),
    .pend_mag (pend_mag_l_q),
    .pend_dir (pend_dir_l_q),
    .pwm      (pwm_l),
    .dir      (dir_l)
  );

  pwm_gen #(
    .Period (PWM_PERIOD),
    .MagW   (MagW)
  ) u_pwm_r (
    .clk      (clk),
    .reset    (reset),
    .pend_mag (pend_mag_r_q),
    .pend_dir (pend_dir_r_q),
    .pwm      (pwm_r),
    .dir      (dir_r)
  );

  assign enabled = en_q;
  assign cmd_seq = seq_q;

endmodule

// File: tb/tb_motor_cmd_reader.sv
// Scoreboard bench for motor_cmd_reader: a register-file responder serves polls,
// stimulus pushes expected commits, a monitor checks each commit and its PWM.
module tb_motor_cmd_reader;

  localparam int unsigned CMD_BASE    = 3;
  localparam int unsigned PWM_PERIOD  = 2500;
  localparam int unsigned POLL_DIV    = 40;
  localparam int unsigned WDOG_CYCLES = 8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_en, rd_ack;
  logic [31:0] rd_addr, rd_data;
  logic        pwm_l, pwm_r, dir_l, dir_r, enabled, timeout;
  logic [7:0]  cmd_seq;

  always #5 clk = ~clk;

  motor_cmd_reader #(
    .CMD_BASE    (CMD_BASE),
    .PWM_PERIOD  (PWM_PERIOD),
    .POLL_DIV    (POLL_DIV),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .pwm_l   (pwm_l),
    .pwm_r   (pwm_r),
    .dir_l   (dir_l),
    .dir_r   (dir_r),
    .enabled (enabled),
    .cmd_seq (cmd_seq),
    .timeout (timeout)
  );

  typedef struct {
    string      name;
    logic [7:0] seq;
    logic       en;
    logic       dl;
    logic       dr;
    int         hl;
    int         hr;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  logic [31:0] regs [0:7];
  logic        hold_mot = 1'b0;
  logic        tear_arm = 1'b0;
  logic [31:0] tear_mot, tear_ctrl;
  logic        busy = 1'b0;
  int unsigned commit_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Register-file responder with 0..2 cycle grant latency and read-protocol checks.
  initial begin
    logic        was_ack, prev_en;
    logic [31:0] rise_addr;
    int          wait_cnt, lat, ridx;
    was_ack = 0; prev_en = 0; rise_addr = 0; wait_cnt = 0; lat = 0; ridx = 0;
    rd_ack = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      rd_ack = 1'b0;
      if (reset) begin
        was_ack = 0; prev_en = 0; wait_cnt = 0; ridx = 0;
      end else begin
        if (was_ack) check("rd_en_low_after_ack", 64'(rd_en), 64'd0);
        was_ack = 0;
        if (rd_en && !prev_en) rise_addr = rd_addr;
        prev_en = rd_en;
        if (!rd_en) begin
          wait_cnt = 0;
        end else if (!(hold_mot && rd_addr == CMD_BASE)) begin
          if (wait_cnt >= lat) begin
            check("rd_addr_order", 64'(rd_addr), (ridx == 1) ? 64'(CMD_BASE) : 64'(CMD_BASE + 1));
            check("rd_addr_stable", 64'(rd_addr), 64'(rise_addr));
            ridx = (ridx + 1) % 3;
            rd_data = regs[rd_addr[2:0]];
            rd_ack = 1'b1;
            was_ack = 1;
            wait_cnt = 0;
            lat = (lat + 1) % 3;
            if (rd_addr == CMD_BASE && tear_arm) begin
              regs[CMD_BASE]     = tear_mot;
              regs[CMD_BASE + 1] = tear_ctrl;
              tear_arm = 1'b0;
            end
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Monitor: every cmd_seq change is a commit; pop and check it, then measure PWM.
  initial begin
    logic [7:0] last_seq;
    int         n_since_rst, hl, hr;
    exp_t       e;
    last_seq = 0;
    n_since_rst = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_seq = 0;
        n_since_rst = 0;
      end else if (cmd_seq !== last_seq) begin
        busy = 1'b1;
        last_seq = cmd_seq;
        commit_cyc = cyc;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_commit: got seq %0d, expected no commit", cmd_seq);
        end else begin
          e = sb.pop_front();
          check({e.name, "_seq"}, 64'(cmd_seq), 64'(e.seq));
          check({e.name, "_enabled"}, 64'(enabled), 64'(e.en));
          check({e.name, "_timeout"}, 64'(timeout), 64'd0);
          if (n_since_rst == 0) check({e.name, "_dir_before_wrap"}, 64'({dir_l, dir_r}), 64'd0);
          n_since_rst++;
          repeat (PWM_PERIOD + 2) @(negedge clk);
          hl = 0;
          hr = 0;
          repeat (PWM_PERIOD) begin
            @(negedge clk);
            hl += int'(pwm_l);
            hr += int'(pwm_r);
          end
          check({e.name, "_high_l"}, 64'(hl), 64'(e.hl));
          check({e.name, "_high_r"}, 64'(hr), 64'(e.hr));
          check({e.name, "_dir_l"}, 64'(dir_l), 64'(e.dl));
          check({e.name, "_dir_r"}, 64'(dir_r), 64'(e.dr));
        end
        busy = 1'b0;
      end
    end
  end

  task automatic push_exp(input string name, input logic [7:0] seq, input logic en,
                          input logic dl, input logic dr, input int hl, input int hr);
    exp_t e;
    e.name = name; e.seq = seq; e.en = en; e.dl = dl; e.dr = dr; e.hl = hl; e.hr = hr;
    sb.push_back(e);
  endtask

  task automatic write_cmd(input logic [31:0] mot, input logic [31:0] ctrl);
    @(posedge clk);
    #2;
    regs[CMD_BASE]     = mot;
    regs[CMD_BASE + 1] = ctrl;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained_in_budget"}, 64'(n < 8000), 64'd1);
  endtask

  task automatic outputs_zero(input string name);
    check(name, {rd_en, rd_addr, pwm_l, pwm_r, dir_l, dir_r, enabled, cmd_seq, timeout}, 64'd0);
  endtask

  initial begin
    int n;
    int hl, hr;
    for (int i = 0; i < 8; i++) regs[i] = '0;
    tear_mot = '0;
    tear_ctrl = '0;
    repeat (3) @(negedge clk);
    outputs_zero("reset_values");
    reset = 1'b0;

    // First poll request exactly POLL_DIV cycles after reset release.
    repeat (POLL_DIV - 1) @(negedge clk);
    check("no_poll_before_div", 64'(rd_en), 64'd0);
    @(negedge clk);
    check("poll_at_div", 64'(rd_en), 64'd1);

    // L=+1250 (50%), R=-625 (25%, reverse).
    push_exp("cmd1", 8'd1, 1'b1, 1'b0, 1'b1, 1250, 625);
    write_cmd(32'h04E2_FD8F, 32'h0000_0101);
    drain("cmd1");

    // Torn: CTRL changes 0x0101 -> 0x0201 (with new MOT) between CTRL_A and CTRL_B.
    tear_mot = 32'hFE0C_07D0;  // L=-500, R=+2000
    tear_ctrl = 32'h0000_0201;
    tear_arm = 1'b1;
    push_exp("torn", 8'd2, 1'b1, 1'b1, 1'b0, 500, 2000);
    drain("torn");

    // Saturation: +3000 and -32768 both clamp to full period.
    push_exp("sat", 8'd3, 1'b1, 1'b0, 1'b1, PWM_PERIOD, PWM_PERIOD);
    write_cmd(32'h0BB8_8000, 32'h0000_0301);
    drain("sat");

    // Disabled: duties ignored, dir and seq still follow the command.
    push_exp("disabled", 8'd4, 1'b0, 1'b0, 1'b1, 0, 0);
    write_cmd(32'h03E8_FC18, 32'h0000_0400);
    drain("disabled");

    // Reset while RD_MOT is stalled.
    hold_mot = 1'b1;
    write_cmd(32'h0064_FF38, 32'h0000_0501);  // L=+100, R=-200
    n = 0;
    while (!(rd_en && rd_addr == CMD_BASE) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("reached_rd_mot", 64'(n < 1000), 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    outputs_zero("reset_mid_read");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hold_mot = 1'b0;
    push_exp("after_reset", 8'd5, 1'b1, 1'b0, 1'b1, 100, 200);
    drain("after_reset");

`ifdef MOTOR_CMD_WDOG_EN
    while (cyc < commit_cyc + WDOG_CYCLES - 1) @(negedge clk);
    check("wdog_not_yet", 64'(timeout), 64'd0);
    @(negedge clk);
    check("wdog_tripped", 64'(timeout), 64'd1);
    repeat (PWM_PERIOD + 2) @(negedge clk);
    hl = 0;
    hr = 0;
    repeat (PWM_PERIOD) begin
      @(negedge clk);
      hl += int'(pwm_l);
      hr += int'(pwm_r);
    end
    check("wdog_pwm_low", 64'(hl + hr), 64'd0);
    check("wdog_timeout_held", 64'(timeout), 64'd1);
    push_exp("wdog_recover", 8'd6, 1'b1, 1'b0, 1'b1, 100, 200);
    write_cmd(32'h0064_FF38, 32'h0000_0601);
    drain("wdog_recover");
`else
    repeat (3000) @(negedge clk);
    hl = int'(timeout);
    hr = 0;
    check("timeout_tied_low", 64'(hl + hr), 64'd0);
`endif

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(10 * 95000);
    $display("FAIL global_timeout: got cycle %0d, expected finish before it", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
